// File: rtl/dmem_if_pkg.sv
// Shared definitions for the data-memory line interface: FSM states,
// beat-counter sizing and the default line geometry and latency.
package dmem_if_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    WDONE
  } state_t;

  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_DEPTH_WORDS    = 1024;
  localparam int DEF_LATENCY        = 3;

  function automatic int beat_w(input int words_per_line);
    return (words_per_line > 1) ? $clog2(words_per_line) : 1;
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// DEPTH_WORDS x 32 word store: one synchronous write port and one
// enabled, registered read port whose output register is resettable.
module dmem_word_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Array contents are never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/dmem_line_server.sv
// Line-granular backing store below the data cache: fixed-latency refill
// bursts with backpressure and writeback bursts ending in a wr_done pulse.
module dmem_line_server
  import dmem_if_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int DEPTH_WORDS    = DEF_DEPTH_WORDS,
  parameter int LATENCY        = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic        wdata_valid,
  input  logic [31:0] wdata,
  output logic        wdata_ready,
  output logic        wr_done,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        rdata_last,
  input  logic        rdata_ready
);

  localparam int OW     = beat_w(WORDS_PER_LINE);
  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int LINE_W = AW - OW;
  localparam int LW     = $clog2(LATENCY + 1);
  localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS_PER_LINE - 1);
  localparam logic [LW-1:0] LAT_LOAD  = LW'(LATENCY - 1);

  state_t            state_reg;
  logic [LINE_W-1:0] line_reg;
  logic              write_reg;
  logic [LW-1:0]     lat_cnt_reg;
  logic [OW-1:0]     beat_reg;
  logic [OW-1:0]     beat_next;
  logic              req_ready_reg;
  logic              wdata_ready_reg;
  logic              wr_done_reg;
  logic              rdata_valid_reg;
  logic              rdata_last_reg;
  logic              mem_we;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_wr_addr;
  logic [AW-1:0]     mem_rd_addr;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[OW+1:0]};

  assign beat_next   = beat_reg + OW'(1);
  assign mem_we      = wdata_ready_reg && wdata_valid;
  assign mem_wr_addr = {line_reg, beat_reg};

  // The read register is loaded one edge ahead: beat 0 while leaving WAIT,
  // then the following beat on each handshake, so rdata is always registered.
  assign mem_rd_en = ((state_reg == WAIT) && (lat_cnt_reg == '0) && !write_reg) ||
                     ((state_reg == RBURST) && rdata_ready && (beat_reg != LAST_BEAT));
  assign mem_rd_addr = (state_reg == RBURST) ? {line_reg, beat_next}
                                             : {line_reg, {OW{1'b0}}};

  dmem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (mem_we),
    .wr_addr(mem_wr_addr),
    .wr_data(wdata),
    .rd_en  (mem_rd_en),
    .rd_addr(mem_rd_addr),
    .rd_data(rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      line_reg        <= '0;
      write_reg       <= 1'b0;
      lat_cnt_reg     <= '0;
      beat_reg        <= '0;
      req_ready_reg   <= 1'b1;
      wdata_ready_reg <= 1'b0;
      wr_done_reg     <= 1'b0;
      rdata_valid_reg <= 1'b0;
      rdata_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready_reg) begin
            line_reg      <= req_addr[AW+1:OW+2];
            write_reg     <= req_write;
            lat_cnt_reg   <= LAT_LOAD;
            req_ready_reg <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt_reg == '0) begin
            beat_reg <= '0;
            if (write_reg) begin
              wdata_ready_reg <= 1'b1;
              state_reg       <= WBURST;
            end else begin
              rdata_valid_reg <= 1'b1;
              rdata_last_reg  <= 1'b0;
              state_reg       <= RBURST;
            end
          end else begin
            lat_cnt_reg <= lat_cnt_reg - LW'(1);
          end
        end
        RBURST: begin
          if (rdata_ready) begin
            if (beat_reg == LAST_BEAT) begin
              rdata_valid_reg <= 1'b0;
              rdata_last_reg  <= 1'b0;
              req_ready_reg   <= 1'b1;
              state_reg       <= IDLE;
            end else begin
              beat_reg       <= beat_next;
              rdata_last_reg <= (beat_next == LAST_BEAT);
            end
          end
        end
        WBURST: begin
          if (wdata_valid) begin
            if (beat_reg == LAST_BEAT) begin
              wdata_ready_reg <= 1'b0;
              wr_done_reg     <= 1'b1;
              state_reg       <= WDONE;
            end else begin
              beat_reg <= beat_next;
            end
          end
        end
        WDONE: begin
          wr_done_reg   <= 1'b0;
          req_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_reg;
  assign wdata_ready = wdata_ready_reg;
  assign wr_done     = wr_done_reg;
  assign rdata_valid = rdata_valid_reg;
  assign rdata_last  = rdata_last_reg;

endmodule

// File: tb/tb_dmem_line_server.sv
// Randomized bench for dmem_line_server: a transaction-level memory model
// predicts every output each cycle, plus literal checks of the directed cases.
module tb_dmem_line_server;

  localparam int WPL   = 4;
  localparam int DEPTH = 1024;
  localparam int LAT   = 3;

  localparam int M_IDLE  = 0;
  localparam int M_READ  = 1;
  localparam int M_WRITE = 2;
  localparam int M_DONE  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic        wdata_valid = 1'b0;
  logic [31:0] wdata = '0;
  logic        wdata_ready;
  logic        wr_done;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        rdata_last;
  logic        rdata_ready = 1'b0;

  int checks   = 0;
  int failures = 0;

  dmem_line_server #(
    .WORDS_PER_LINE(WPL),
    .DEPTH_WORDS   (DEPTH),
    .LATENCY       (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .wdata_valid(wdata_valid),
    .wdata      (wdata),
    .wdata_ready(wdata_ready),
    .wr_done    (wr_done),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .rdata_last (rdata_last),
    .rdata_ready(rdata_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents plus the current transaction described
  // as (kind, cycle its burst opens, beats completed, line base word).
  logic [31:0] mem_m   [DEPTH];
  bit          known_m [DEPTH];
  int mode_m  = M_IDLE;
  int start_m = 0;
  int beats_m = 0;
  int base_m  = 0;
  int cyc     = 0;
  bit open_m;

  function automatic int line_base(input logic [31:0] a);
    int w;
    w = int'((a >> 2) % DEPTH);
    return (w / WPL) * WPL;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_m  = M_IDLE;
      beats_m = 0;
    end else begin
      open_m = (cyc >= start_m);
      case (mode_m)
        M_IDLE: begin
          if (req_valid) begin
            base_m  = line_base(req_addr);
            mode_m  = req_write ? M_WRITE : M_READ;
            start_m = cyc + 1 + LAT;
            beats_m = 0;
          end
        end
        M_READ: begin
          if (open_m && rdata_ready) begin
            beats_m++;
            if (beats_m == WPL) mode_m = M_IDLE;
          end
        end
        M_WRITE: begin
          if (open_m && wdata_valid) begin
            mem_m[base_m + beats_m]   = wdata;
            known_m[base_m + beats_m] = 1'b1;
            beats_m++;
            if (beats_m == WPL) mode_m = M_DONE;
          end
        end
        default: mode_m = M_IDLE;
      endcase
      cyc++;
    end
  end

  always @(negedge clk) begin
    bit exp_rv;
    bit exp_wr;
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
      chk("rst_wr_done", 32'(wr_done), 32'd0);
      chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_rdata_last", 32'(rdata_last), 32'd0);
    end else begin
      exp_rv = (mode_m == M_READ) && (cyc >= start_m);
      exp_wr = (mode_m == M_WRITE) && (cyc >= start_m);
      chk("cyc_req_ready", 32'(req_ready), 32'(mode_m == M_IDLE));
      chk("cyc_wdata_ready", 32'(wdata_ready), 32'(exp_wr));
      chk("cyc_wr_done", 32'(wr_done), 32'(mode_m == M_DONE));
      chk("cyc_rdata_valid", 32'(rdata_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("cyc_rdata_last", 32'(rdata_last), 32'(beats_m == WPL - 1));
        if (known_m[base_m + beats_m]) begin
          chk("cyc_rdata", rdata, mem_m[base_m + beats_m]);
        end
      end
    end
  end

  // All driver tasks start and end at a falling edge.
  task automatic issue_req(input bit wr, input logic [31:0] addr);
    int g;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    g = 0;
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("req_accept_timeout", 32'(g < 100), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_req(input bit wr, input logic [31:0] addr,
                         input logic [WPL-1:0][31:0] d, input int mode,
                         output int lat, output logic [WPL-1:0][31:0] got,
                         output int last_pos, output int span);
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int k, i, step, first;
    bit busy;
    issue_req(wr, addr);
    k = 0; i = 0; step = 0; first = 0;
    lat = -1; last_pos = -1; span = -1; got = '0;
    while (i < WPL && k < 400) begin
      busy = wr ? wdata_ready : rdata_valid;
      if (busy && lat < 0) begin
        lat   = k;
        first = k;
      end
      if (wr) begin
        wdata       = d[i];
        wdata_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (wdata_ready && wdata_valid) begin
          i++;
          if (i == WPL) span = k - first + 1;
        end
      end else begin
        if (mode == 0) rdata_ready = 1'b1;
        else if (mode == 1) rdata_ready = (step < 7) ? 1'(pat[step]) : 1'b1;
        else rdata_ready = 1'($urandom_range(0, 1));
        if (busy) step++;
        if (rdata_valid && rdata_ready) begin
          got[i] = rdata;
          if (rdata_last) last_pos = i;
          i++;
          if (i == WPL) span = k - first + 1;
        end
      end
      @(negedge clk);
      k++;
    end
    wdata_valid = 1'b0;
    rdata_ready = 1'b0;
    chk("burst_timeout", 32'(i), 32'(WPL));
  endtask

  initial begin
    logic [WPL-1:0][31:0] d1, d2, dr, got;
    int lat, lp, span, acc, hs, g;
    logic [31:0] addr;

    d1 = {32'h44, 32'h33, 32'h22, 32'h11};
    d2 = {32'hDD, 32'hCC, 32'hBB, 32'hAA};

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Writeback of line 0x40
    run_req(1'b1, 32'h0000_0040, d1, 0, lat, got, lp, span);
    chk("wb_latency", 32'(lat), 32'd3);
    chk("wb_span", 32'(span), 32'd4);
    chk("wb_done_pulse", 32'(wr_done), 32'd1);
    @(negedge clk);
    chk("wb_done_once", 32'(wr_done), 32'd0);
    chk("wb_req_ready_back", 32'(req_ready), 32'd1);

    // Refill with offset bits set
    run_req(1'b0, 32'h0000_0048, d1, 0, lat, got, lp, span);
    chk("rf_beat0", got[0], 32'h11);
    chk("rf_beat1", got[1], 32'h22);
    chk("rf_beat2", got[2], 32'h33);
    chk("rf_beat3", got[3], 32'h44);
    chk("rf_last_pos", 32'(lp), 32'd3);
    chk("rf_latency", 32'(lat), 32'd3);
    chk("rf_span", 32'(span), 32'd4);

    // Refill with ready pattern 1,0,0,1,1,0,1
    run_req(1'b0, 32'h0000_0040, d1, 1, lat, got, lp, span);
    for (int i = 0; i < WPL; i++) chk("stall_beat", got[i], d1[i]);
    chk("stall_last_pos", 32'(lp), 32'd3);
    chk("stall_span", 32'(span), 32'd7);

    // Two back-to-back refills with req_valid held high
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040; rdata_ready = 1'b1;
    acc = 0; hs = 0;
    for (int n = 0; n < 16; n++) begin
      if (req_valid && req_ready) acc++;
      if (rdata_valid && rdata_ready) hs++;
      @(negedge clk);
    end
    req_valid = 1'b0; rdata_ready = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd2);
    chk("b2b_beats", 32'(hs), 32'd8);

    // Reset in the middle of a refill, after two beats
    issue_req(1'b0, 32'h0000_0040);
    rdata_ready = 1'b1; hs = 0; g = 0;
    while (hs < 2 && g < 50) begin
      if (rdata_valid && rdata_ready) hs++;
      @(negedge clk);
      g++;
    end
    chk("mid_beats_before_rst", 32'(hs), 32'd2);
    chk("mid_valid_before_rst", 32'(rdata_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_rdata_last", 32'(rdata_last), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    rdata_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    run_req(1'b0, 32'h0000_0040, d1, 0, lat, got, lp, span);
    for (int i = 0; i < WPL; i++) chk("after_rst_beat", got[i], d1[i]);

    // Address wrap: 0x1040 aliases 0x40
    run_req(1'b1, 32'h0000_1040, d2, 0, lat, got, lp, span);
    run_req(1'b0, 32'h0000_0040, d1, 0, lat, got, lp, span);
    for (int i = 0; i < WPL; i++) chk("wrap_beat", got[i], d2[i]);

    // Random traffic over a few aliased lines
    for (int t = 0; t < 40; t++) begin
      addr = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 4) |
             32'($urandom_range(0, 15));
      for (int i = 0; i < WPL; i++) dr[i] = $urandom;
      run_req(1'($urandom_range(0, 1)), addr, dr, 2, lat, got, lp, span);
      chk("rand_latency", 32'(lat), 32'(LAT));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_line_server.md
# dmem_line_server

Backing-store responder for the data cache's line-refill and line-writeback traffic. The cache acts as the initiator: it issues one line-granular request, then moves whole lines one 32-bit beat at a time. This block is the memory end of that interface. It holds the word array, applies a fixed access latency, streams refill beats with backpressure, and absorbs writeback beats. It sits directly below the cache, in place of the ideal data memory, in the full-path pipeline.

## Interface
Parameters:
- WORDS_PER_LINE, 4, beats per line; power of two, at least 2
- DEPTH_WORDS, 1024, array size in 32-bit words; power of two
- LATENCY, 3, cycles from request acceptance to the first data beat or the first write-ready; at least 1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = writeback, 0 = refill
- req_addr  in  32  byte address; low log2(WORDS_PER_LINE)+2 bits are ignored
- wdata_valid  in  1  writeback beat present
- wdata  in  32  writeback beat
- wdata_ready  out  1  block accepts a writeback beat
- wr_done  out  1  one-cycle pulse when a writeback is committed
- rdata_valid  out  1  refill beat present
- rdata  out  32  refill beat, registered
- rdata_last  out  1  marks the final beat of the line
- rdata_ready  in  1  cache accepts the refill beat

## Operation
- FSM states: IDLE, WAIT, RBURST, WBURST, WDONE.
- IDLE: req_ready=1. A request is accepted when req_valid&&req_ready is high at an edge. The block then captures the line base and the write flag, loads the latency counter with LATENCY-1, and moves to WAIT.
- WAIT: the counter decrements each cycle. At 0 the FSM moves to RBURST (read) or WBURST (write), and the beat counter is cleared.
- RBURST: rdata_valid=1 and rdata = array[base+beat]. A beat completes on rdata_valid&&rdata_ready. With rdata_ready low, rdata, rdata_valid and rdata_last hold. rdata_last=1 when beat==WORDS_PER_LINE-1. Completion of that last beat returns the FSM to IDLE.
- WBURST: wdata_ready=1. On wdata_valid&&wdata_ready, array[base+beat] is written with wdata and beat increments. Completion of the last beat moves the FSM to WDONE.
- WDONE: wr_done=1 for exactly one cycle, then IDLE.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2] with the offset bits zeroed. Higher address bits are dropped, so addresses wrap modulo DEPTH_WORDS. Beats never cross a line.
- req_ready is 0 in every state except IDLE. A request held during a burst waits and is not lost.
- Reset values: FSM=IDLE, req_ready=1, wdata_ready=0, wr_done=0, rdata_valid=0, rdata=0, rdata_last=0, counters=0.
- Reset does not clear the array. Its contents are undefined until written.
- Reset mid-burst aborts the burst. Writeback beats already written stay written. No wr_done is issued for the aborted writeback.

## Timing
- Request accepted at edge T. The first rdata_valid, or the first wdata_ready, is high in the cycle following edge T+LATENCY.
- Refill with rdata_ready held high: beats occupy WORDS_PER_LINE consecutive cycles, and req_ready returns the cycle after the last beat.
- Writeback with wdata_valid held high: the last beat is accepted at edge E, wr_done is high in the following cycle, and req_ready is high one cycle after that.
- A write to a word, followed by a read of the same word in a later request, returns the new data; there is no hazard, because requests are serialized.
- rdata updates only on a beat handshake or on a state entry. It is glitch-free and registered.

## Structure
- Shared package dmem_if_pkg holds:
  - the state enum (IDLE/WAIT/RBURST/WBURST/WDONE)
  - the beat-count width function
  - default constants for the line size and the latency
- One sub-module, dmem_word_array: synchronous single-port write, one read port, DEPTH_WORDS×32. The FSM prefetches the next read address so rdata stays registered.

## Test plan
- Writeback of line 0x0000_0040 with beats 0x11,0x22,0x33,0x44 and wdata_valid always high, LATENCY=3 -> wdata_ready rises 3 cycles after acceptance, 4 beats are taken in 4 cycles, wr_done pulses once.
- Refill of 0x0000_0048 (offset ignored) -> beats 0x11,0x22,0x33,0x44 with rdata_last on 0x44, and the first rdata_valid arrives 3 cycles after acceptance.
- Refill with rdata_ready toggled 1,0,0,1,1,0,1 -> every beat is delivered exactly once, in order, and values hold while stalled.
- req_valid held high throughout two back-to-back requests -> req_ready is 0 during the busy state, and the second request is accepted only after the first completes.
- Wrap: a write at 0x0000_1040 with DEPTH_WORDS=1024, then a refill from 0x0000_0040 -> returns the written data.
- rst asserted mid-refill after beat 2 -> all outputs go to reset values immediately, and a subsequent refill returns the intact array contents.
